current_sense_avg: RTL and testbench
====================================

Name: current_sense_avg

Overview:
- Upstream feeder of the seven-segment display controller; produces its 16-bit `current_num` value in mA.
- Paces a 12-bit current-sense ADC with periodic start/done handshakes and averages 2^AVG_LOG2 samples.
- Scales the mean to mA, saturates to the 3-digit display range, and presents a held value plus an update strobe.
- Runs on the 100 MHz board clock.

Parameters:
- SAMPLE_PERIOD, 100000: clk cycles between conversion requests (1 kHz at 100 MHz); min 4.
- TIMEOUT, 1000: max clk cycles to wait for a conversion result after adc_start.
- ADC_BITS, 12: width of sample_data.
- AVG_LOG2, 4: log2 of samples per averaging window (1..8).
- SCALE_NUM, 500: mA multiplier applied to the mean code (16-bit unsigned).
- SCALE_SHIFT, 10: right shift after the multiply (4095 -> 1999 mA with defaults).
- MAX_DISPLAY, 999: saturation ceiling for current_num.
- OC_LIMIT_MA, 900: overcurrent threshold in mA (used only with OVERCURRENT_EN).

Ports:
- clk, input, 1: 100 MHz clock; all logic is on posedge.
- rst, input, 1: synchronous, active-high reset.
- adc_start, output, 1: one-cycle conversion request to the ADC interface.
- sample_valid, input, 1: one-cycle strobe; sample_data is valid in that cycle.
- sample_data, input, ADC_BITS: raw unsigned ADC code.
- oc_clear, input, 1: clears the overcurrent latch.
- current_num, output, 16: averaged current in mA, 0..MAX_DISPLAY, held between updates.
- current_valid, output, 1: one-cycle pulse when current_num changes value source (new window result).
- adc_fault, output, 1: sticky; set on conversion timeout.
- overcurrent, output, 1: latched overcurrent flag.

Behaviour:
- Reset values: adc_start=0, current_num=0, current_valid=0, adc_fault=0, overcurrent=0.
- Reset also clears the period counter, the accumulator, the window count, the pipeline valids, and the FSM (to IDLE).
- Reset mid-window or mid-pipeline discards everything; no current_valid is emitted afterwards.
- Period counter:
  - Counts 0..SAMPLE_PERIOD-1 and wraps; the tick is the cycle in which the count equals SAMPLE_PERIOD-1.
  - It runs freely regardless of FSM state.
- FSM, two states:
  - IDLE + tick: adc_start=1 for that cycle; next state BUSY; timeout counter cleared.
  - IDLE + sample_valid: the sample is ignored (not accumulated).
  - BUSY + sample_valid: the sample is accepted; next state IDLE.
  - BUSY with no sample_valid: timeout counter increments. When it reaches TIMEOUT-1 without sample_valid, adc_fault is set (sticky until rst), no sample is accepted, the window count is unchanged, and the FSM goes to IDLE.
  - A tick arriving while BUSY is dropped: no adc_start is issued and no request is queued.
  - sample_valid in the same cycle as the timeout is accepted; no fault is set.
- Accumulation:
  - Accumulator width is ADC_BITS+AVG_LOG2, so it cannot overflow.
  - On accept: acc <= acc + sample_data and cnt <= cnt + 1.
  - On the accept where cnt == 2^AVG_LOG2-1 (window close):
    - stage-1 register <= (acc + sample_data) >> AVG_LOG2 (truncating);
    - acc <= 0 and cnt <= 0 in the same edge;
    - stage-1 valid is set.
- Pipeline (window close at edge N):
  - Edge N+1: prod <= (mean * SCALE_NUM) >> SCALE_SHIFT, computed at full ADC_BITS+16 width, no truncation before the shift.
  - Edge N+2: current_num <= min(prod, MAX_DISPLAY); current_valid=1 for exactly that one cycle.
  - Latency is 2 cycles from the window-closing accept edge to the current_num update.
  - Windows cannot overlap in the pipeline because SAMPLE_PERIOD >= 4.
- current_num holds its value indefinitely between updates and through adc_fault.

Optional Feature:
- Macro: OVERCURRENT_EN.
- When defined:
  - overcurrent is set on the edge where current_num is loaded with a value > OC_LIMIT_MA (pre-saturation prod is compared, so values above MAX_DISPLAY also trip).
  - It stays set until rst or oc_clear.
  - If oc_clear and a set condition occur in the same cycle, set wins.
- When undefined:
  - overcurrent is constant 0 and oc_clear is ignored.
  - No comparator logic is synthesized.

Test Plan (SAMPLE_PERIOD=20, TIMEOUT=8, AVG_LOG2=2, other parameters default):
1. After rst, answer each adc_start 3 cycles later with 1000, 1000, 1024, 1072 -> sum 4096, mean 1024, current_num=500 two cycles after the 4th accept; single current_valid pulse; adc_start recurs every 20 cycles.
2. Four samples of 4095 -> prod 1999 -> current_num=999. With OVERCURRENT_EN, overcurrent=1; oc_clear then drops it; without the macro it stays 0.
3. Never answer one adc_start -> adc_fault=1 eight cycles after the request; window count unchanged; the next three good samples do not yet update current_num, and the fourth does.
4. Pulse sample_valid in IDLE (value 4095) between requests, then a normal window of 100 x4 -> current_num=48 (100*500>>10); the stray sample is not included.
5. Assert rst after two accepted samples of 4095, then run a window of 2048 x4 -> no output during/after reset until current_num=1000->999 saturated? Expected: 2048*500>>10=1000 -> current_num=999; adc_fault=0 and current_num=0 observed right after reset.
6. Assert sample_valid on the exact timeout cycle with 400 -> accepted, adc_fault stays 0.

Source files
------------

// File: rtl/current_sense_avg.sv
`default_nettype none
// ============================================================================
// Module      : current_sense_avg
// Description : Paces a current-sense ADC with periodic start/done handshakes,
//               averages 2^AVG_LOG2 samples per window, and scales the mean to
//               mA. The result is saturated to the 3-digit display range and
//               held for the seven-segment display controller, with a one-cycle
//               update strobe.
//
// Ports       : clk           - 100 MHz board clock, all logic on posedge
//               rst           - synchronous active-high reset
//               adc_start     - one-cycle conversion request
//               sample_valid  - one-cycle strobe qualifying sample_data
//               sample_data   - raw unsigned ADC code
//               oc_clear      - clears the overcurrent latch
//               current_num   - averaged current in mA, 0..MAX_DISPLAY, held
//               current_valid - one-cycle pulse on each new window result
//               adc_fault     - sticky conversion-timeout flag
//               overcurrent   - latched overcurrent flag
//
// Options     : OVERCURRENT_EN - when defined, builds the overcurrent latch;
//               otherwise overcurrent is tied low and oc_clear is ignored.
//
// Revision    : 1.0 - initial release
// ============================================================================
module current_sense_avg #(
    parameter int SAMPLE_PERIOD = 100000,
    parameter int TIMEOUT       = 1000,
    parameter int ADC_BITS      = 12,
    parameter int AVG_LOG2      = 4,
    parameter int SCALE_NUM     = 500,
    parameter int SCALE_SHIFT   = 10,
    parameter int MAX_DISPLAY   = 999,
    parameter int OC_LIMIT_MA   = 900
) (
    input  logic                clk,
    input  logic                rst,
    output logic                adc_start,
    input  logic                sample_valid,
    input  logic [ADC_BITS-1:0] sample_data,
    input  logic                oc_clear,
    output logic [15:0]         current_num,
    output logic                current_valid,
    output logic                adc_fault,
    output logic                overcurrent
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int c_PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int c_TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int c_AW = ADC_BITS + AVG_LOG2;   // accumulator cannot overflow
    localparam int c_MW = ADC_BITS + 16;         // full multiply width

    localparam logic [c_PW-1:0]     c_PERIOD_LAST = c_PW'(SAMPLE_PERIOD - 1);
    localparam logic [c_TW-1:0]     c_TO_LAST     = c_TW'(TIMEOUT - 1);
    localparam logic [AVG_LOG2-1:0] c_CNT_LAST    = '1;
    localparam logic [c_MW-1:0]     c_SCALE       = c_MW'(SCALE_NUM);
    localparam logic [c_MW-1:0]     c_MAX         = c_MW'(MAX_DISPLAY);
    localparam logic [c_MW-1:0]     c_OC_LIMIT    = c_MW'(OC_LIMIT_MA);

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    // ------------------------------------------------------------------------
    // Free-running period counter
    // ------------------------------------------------------------------------
    logic [c_PW-1:0] r_period_cnt;
    logic            w_tick;

    assign w_tick = (r_period_cnt == c_PERIOD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_cnt <= '0;
        end else if (w_tick) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + c_PW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Conversion handshake FSM
    // A tick seen in BUSY is simply dropped, so at most one request is ever
    // outstanding. A sample coinciding with the timeout cycle wins.
    // ------------------------------------------------------------------------
    logic [0:0]      r_state;
    logic            r_adc_start;
    logic [c_TW-1:0] r_to_cnt;
    logic            r_fault;
    logic            w_accept;

    assign w_accept = (r_state == c_ST_BUSY) && sample_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_adc_start <= 1'b0;
            r_to_cnt    <= '0;
            r_fault     <= 1'b0;
        end else begin
            r_adc_start <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_tick) begin
                        r_adc_start <= 1'b1;
                        r_to_cnt    <= '0;
                        r_state     <= c_ST_BUSY;
                    end
                end
                c_ST_BUSY: begin
                    if (sample_valid) begin
                        r_state <= c_ST_IDLE;
                    end else if (r_to_cnt == c_TO_LAST) begin
                        r_fault <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TW'(1);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Window accumulator; the closing sample is folded in directly so the
    // accumulator can be cleared on the same edge.
    // ------------------------------------------------------------------------
    logic [c_AW-1:0]     r_acc;
    logic [AVG_LOG2-1:0] r_cnt;
    logic [c_AW-1:0]     w_sum;
    logic [ADC_BITS-1:0] r_mean;
    logic                r_mean_vld;

    assign w_sum = r_acc + c_AW'(sample_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_mean     <= '0;
            r_mean_vld <= 1'b0;
        end else begin
            r_mean_vld <= 1'b0;
            if (w_accept) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_mean     <= w_sum[c_AW-1:AVG_LOG2];
                    r_mean_vld <= 1'b1;
                    r_acc      <= '0;
                    r_cnt      <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + AVG_LOG2'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Scale stage: full-width product, shifted after the multiply
    // ------------------------------------------------------------------------
    logic [c_MW-1:0] w_mult;
    logic [c_MW-1:0] r_prod;
    logic            r_prod_vld;

    assign w_mult = c_MW'(r_mean) * c_SCALE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
        end else begin
            r_prod_vld <= r_mean_vld;
            if (r_mean_vld) begin
                r_prod <= w_mult >> SCALE_SHIFT;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Saturating output register
    // ------------------------------------------------------------------------
    logic [15:0] r_current_num;
    logic        r_current_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_current_num <= '0;
            r_current_vld <= 1'b0;
        end else begin
            r_current_vld <= r_prod_vld;
            if (r_prod_vld) begin
                if (r_prod > c_MAX) begin
                    r_current_num <= 16'(MAX_DISPLAY);
                end else begin
                    r_current_num <= r_prod[15:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Optional overcurrent latch. The unsaturated product is compared so
    // readings clipped at MAX_DISPLAY still trip. Set has priority over clear.
    // ------------------------------------------------------------------------
`ifdef OVERCURRENT_EN
    logic r_overcurrent;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overcurrent <= 1'b0;
        end else if (r_prod_vld && (r_prod > c_OC_LIMIT)) begin
            r_overcurrent <= 1'b1;
        end else if (oc_clear) begin
            r_overcurrent <= 1'b0;
        end
    end

    assign overcurrent = r_overcurrent;
`else
    logic [1:0] w_unused_oc;

    assign w_unused_oc = {oc_clear, c_OC_LIMIT[0]};
    assign overcurrent = 1'b0;
`endif

    assign adc_start     = r_adc_start;
    assign adc_fault     = r_fault;
    assign current_num   = r_current_num;
    assign current_valid = r_current_vld;

endmodule
`default_nettype wire

// File: tb/tb_current_sense_avg.sv
`default_nettype none
// ============================================================================
// Module      : tb_current_sense_avg
// Description : Self-checking bench for current_sense_avg. Directed stimulus
//               answers the ADC handshake; expected display values are pushed
//               into a queue and a separate monitor pops them on each
//               current_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_current_sense_avg;

    localparam int c_ADC_BITS = 12;

    logic                  clk;
    logic                  rst;
    logic                  adc_start;
    logic                  sample_valid;
    logic [c_ADC_BITS-1:0] sample_data;
    logic                  oc_clear;
    logic [15:0]           current_num;
    logic                  current_valid;
    logic                  adc_fault;
    logic                  overcurrent;

    int r_errors = 0;
    int r_checks = 0;
    int r_cyc    = 0;
    int r_exp_q[$];

    current_sense_avg #(
        .SAMPLE_PERIOD (20),
        .TIMEOUT       (8),
        .ADC_BITS      (c_ADC_BITS),
        .AVG_LOG2      (2)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .adc_start     (adc_start),
        .sample_valid  (sample_valid),
        .sample_data   (sample_data),
        .oc_clear      (oc_clear),
        .current_num   (current_num),
        .current_valid (current_valid),
        .adc_fault     (adc_fault),
        .overcurrent   (overcurrent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) r_cyc <= r_cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        r_checks++;
        if (act != exp) begin
            r_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, r_cyc);
        end
    endtask

    // Monitor: every update pulse must match the oldest expected value.
    always @(negedge clk) begin
        if (!rst && current_valid) begin
            if (r_exp_q.size() == 0) begin
                chk("unexpected_current_valid", 1, 0);
            end else begin
                chk("current_num", int'(current_num), r_exp_q.pop_front());
            end
        end
    end

    // Wait for a request, then answer it d cycles after the request cycle.
    // d < 0 leaves the request unanswered. Returns at the negedge of the
    // request cycle (unanswered) or #1 after the accepting edge.
    task automatic issue(input int d, input int v, output int t_req);
        int n;
        n = 0;
        @(negedge clk);
        while (!adc_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!adc_start) begin
            chk("adc_start_wait", 0, 1);
            t_req = -1;
            return;
        end
        t_req = r_cyc;
        if (d < 0) return;
        repeat (d) @(posedge clk);
        #1;
        sample_valid = 1'b1;
        sample_data  = c_ADC_BITS'(v);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        sample_data  = '0;
    endtask

    task automatic check_oc(input string name, input int exp_on);
`ifdef OVERCURRENT_EN
        chk(name, int'(overcurrent), exp_on);
`else
        chk(name, int'(overcurrent), 0);
`endif
    endtask

    initial begin
        int t0, t1, t2, t3;
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_data  = '0;
        oc_clear     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_adc_start", int'(adc_start), 0);
        chk("rst_current_num", int'(current_num), 0);
        chk("rst_current_valid", int'(current_valid), 0);
        chk("rst_adc_fault", int'(adc_fault), 0);
        chk("rst_overcurrent", int'(overcurrent), 0);
        rst = 1'b0;

        // 1: 1000+1000+1024+1072 = 4096, mean 1024 -> 1024*500>>10 = 500
        issue(3, 1000, t0);
        issue(3, 1000, t1);
        issue(3, 1024, t2);
        r_exp_q.push_back(500);
        issue(3, 1072, t3);
        chk("adc_start_period_a", t1 - t0, 20);
        chk("adc_start_period_b", t2 - t1, 20);
        chk("adc_start_period_c", t3 - t2, 20);
        @(posedge clk);
        #1;
        chk("latency_not_early", int'(current_valid), 0);
        @(posedge clk);
        #1;
        chk("latency_valid", int'(current_valid), 1);
        chk("latency_value", int'(current_num), 500);

        // 2: 4095 x4 -> 1999 mA, saturated to 999
        repeat (3) issue(3, 4095, t0);
        r_exp_q.push_back(999);
        issue(3, 4095, t0);
        repeat (3) @(posedge clk);
        #1;
        check_oc("oc_set", 1);
        oc_clear = 1'b1;
        @(posedge clk);
        #1;
        oc_clear = 1'b0;
        check_oc("oc_cleared", 0);

        // 3: unanswered request -> fault exactly 8 cycles after request
        issue(-1, 0, t0);
        repeat (7) @(posedge clk);
        #1;
        chk("fault_not_early", int'(adc_fault), 0);
        @(posedge clk);
        #1;
        chk("fault_set", int'(adc_fault), 1);
        chk("hold_through_fault", int'(current_num), 999);
        // 200*500>>10 = 97; three samples must not close the window
        repeat (3) issue(3, 200, t0);
        r_exp_q.push_back(97);
        issue(3, 200, t0);
        chk("fault_sticky", int'(adc_fault), 1);

        // 4: stray IDLE sample ignored; 100*500>>10 = 48
        issue(3, 100, t0);
        repeat (4) @(posedge clk);
        #1;
        sample_valid = 1'b1;
        sample_data  = 12'd4095;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        sample_data  = '0;
        issue(3, 100, t0);
        issue(3, 100, t0);
        r_exp_q.push_back(48);
        issue(3, 100, t0);

        // 5: reset mid-window discards partial sum; 2048*500>>10 = 1000 -> 999
        issue(3, 4095, t0);
        issue(3, 4095, t0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst2_adc_fault", int'(adc_fault), 0);
        chk("rst2_current_num", int'(current_num), 0);
        repeat (3) issue(3, 2048, t0);
        r_exp_q.push_back(999);
        issue(3, 2048, t0);
        repeat (3) @(posedge clk);
        #1;
        check_oc("oc_after_rst_window", 1);

        // 6: sample on the timeout cycle is accepted; 400*500>>10 = 195
        repeat (3) issue(3, 400, t0);
        r_exp_q.push_back(195);
        issue(7, 400, t0);
        repeat (4) @(posedge clk);
        #1;
        chk("timeout_cycle_no_fault", int'(adc_fault), 0);

        repeat (10) @(posedge clk);
        chk("queue_drained", r_exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
        $finish;
    end

endmodule
`default_nettype wire
